// File: rtl/ntt_banked_sram_arb_wrapper.sv
// Word-interleaved banked coefficient memory shared by bus and accelerator ports.
// Same-bank conflicts favour acc, bounded by a bus starvation counter.
module ntt_banked_sram_arb_wrapper #(
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumBanks   = 4,
    parameter int unsigned AddrWidth  = $clog2(NumWords * NumBanks),
    parameter int unsigned WakeCycles = 4,
    parameter int unsigned MaxStall   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   bus_req_i,
    input  logic                   bus_we_i,
    input  logic [AddrWidth-1:0]   bus_addr_i,
    input  logic [DataWidth-1:0]   bus_wdata_i,
    input  logic [DataWidth/8-1:0] bus_be_i,
    output logic                   bus_gnt_o,
    output logic                   bus_rvalid_o,
    output logic [DataWidth-1:0]   bus_rdata_o,
    input  logic                   acc_req_i,
    input  logic                   acc_we_i,
    input  logic [AddrWidth-1:0]   acc_addr_i,
    input  logic [DataWidth-1:0]   acc_wdata_i,
    input  logic [DataWidth/8-1:0] acc_be_i,
    output logic                   acc_gnt_o,
    output logic                   acc_rvalid_o,
    output logic [DataWidth-1:0]   acc_rdata_o,
    input  logic                   set_retentive_i,
    output logic                   retentive_o
);

    localparam int unsigned BankBits = $clog2(NumBanks);
    localparam int unsigned RowWidth = AddrWidth - BankBits;
    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned StallW   =
        (MaxStall < 1) ? 1 : $clog2(MaxStall + 1);
    localparam int unsigned WakeW    =
        (WakeCycles < 2) ? 1 : $clog2(WakeCycles);

    typedef enum logic [1:0] {
        ACTIVE,
        RET_ENTRY,
        RETENTIVE,
        WAKE
    } state_t;

    state_t              state;
    logic [WakeW-1:0]    wake_cnt;
    logic [StallW-1:0]   stall_cnt;

    logic [BankBits-1:0] bus_bank;
    logic [BankBits-1:0] acc_bank;
    logic [RowWidth-1:0] bus_row;
    logic [RowWidth-1:0] acc_row;
    logic                active;
    logic                conflict;
    logic                bus_prio;

    logic [DataWidth-1:0] mem [NumBanks][NumWords];

    logic [NumBanks-1:0]  bank_req;
    logic [NumBanks-1:0]  bank_we;
    logic [RowWidth-1:0]  bank_row   [NumBanks];
    logic [DataWidth-1:0] bank_wdata [NumBanks];
    logic [BeWidth-1:0]   bank_be    [NumBanks];

    assign bus_bank = bus_addr_i[BankBits-1:0];
    assign acc_bank = acc_addr_i[BankBits-1:0];
    assign bus_row  = bus_addr_i[AddrWidth-1:BankBits];
    assign acc_row  = acc_addr_i[AddrWidth-1:BankBits];

    assign active   = (state == ACTIVE);
    assign conflict = bus_req_i & acc_req_i & (bus_bank == acc_bank);
    assign bus_prio = conflict & (stall_cnt == StallW'(MaxStall));

    assign bus_gnt_o = active & bus_req_i & (~conflict | bus_prio);
    assign acc_gnt_o = active & acc_req_i & ~bus_prio;

    // Grants never collide on a bank, so each bank sees at most one owner.
    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            bank_req[b]   = 1'b0;
            bank_we[b]    = 1'b0;
            bank_row[b]   = '0;
            bank_wdata[b] = '0;
            bank_be[b]    = '0;
            if (bus_gnt_o && bus_bank == BankBits'(b)) begin
                bank_req[b]   = 1'b1;
                bank_we[b]    = bus_we_i;
                bank_row[b]   = bus_row;
                bank_wdata[b] = bus_wdata_i;
                bank_be[b]    = bus_be_i;
            end else if (acc_gnt_o && acc_bank == BankBits'(b)) begin
                bank_req[b]   = 1'b1;
                bank_we[b]    = acc_we_i;
                bank_row[b]   = acc_row;
                bank_wdata[b] = acc_wdata_i;
                bank_be[b]    = acc_be_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NumBanks; b++) begin
            for (int i = 0; i < BeWidth; i++) begin
                if (bank_req[b] && bank_we[b] && bank_be[b][i]) begin
                    mem[b][bank_row[b]][8*i +: 8] <=
                        bank_wdata[b][8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_rvalid_o <= 1'b0;
            acc_rvalid_o <= 1'b0;
            bus_rdata_o  <= '0;
            acc_rdata_o  <= '0;
        end else begin
            bus_rvalid_o <= bus_gnt_o & ~bus_we_i;
            acc_rvalid_o <= acc_gnt_o & ~acc_we_i;
            if (bus_gnt_o && !bus_we_i) begin
                bus_rdata_o <= mem[bus_bank][bus_row];
            end
            if (acc_gnt_o && !acc_we_i) begin
                acc_rdata_o <= mem[acc_bank][acc_row];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!bus_req_i || bus_gnt_o) begin
            stall_cnt <= '0;
        end else if (active && conflict) begin
            stall_cnt <= stall_cnt + StallW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ACTIVE;
            wake_cnt    <= '0;
            retentive_o <= 1'b0;
        end else begin
            unique case (state)
                ACTIVE: begin
                    if (set_retentive_i) begin
                        state       <= RET_ENTRY;
                        retentive_o <= 1'b1;
                    end
                end
                RET_ENTRY: begin
                    state <= RETENTIVE;
                end
                RETENTIVE: begin
                    if (!set_retentive_i) begin
                        state    <= WAKE;
                        wake_cnt <= '0;
                    end
                end
                WAKE: begin
                    if (wake_cnt == WakeW'(WakeCycles - 1)) begin
                        state       <= ACTIVE;
                        retentive_o <= 1'b0;
                    end else begin
                        wake_cnt <= wake_cnt + WakeW'(1);
                    end
                end
                default: begin
                    state       <= ACTIVE;
                    retentive_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_banked_sram_arb_wrapper.sv
// Directed bench for the banked SRAM wrapper: read data is checked
// by a monitor popping per-port scoreboard queues.
module tb_ntt_banked_sram_arb_wrapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [11:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        acc_req, acc_we, acc_gnt, acc_rvalid;
    logic [11:0] acc_addr;
    logic [31:0] acc_wdata, acc_rdata;
    logic [3:0]  acc_be;
    logic        set_ret, ret;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] bus_exp_q[$];
    int          bus_cyc_q[$];
    logic [31:0] acc_exp_q[$];
    int          acc_cyc_q[$];

    int wb, wa, w1, w2;
    int wacc[7];
    int exp_wacc[7] = '{0, 0, 0, 1, 0, 0, 0};

    ntt_banked_sram_arb_wrapper dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bus_req_i       (bus_req),
        .bus_we_i        (bus_we),
        .bus_addr_i      (bus_addr),
        .bus_wdata_i     (bus_wdata),
        .bus_be_i        (bus_be),
        .bus_gnt_o       (bus_gnt),
        .bus_rvalid_o    (bus_rvalid),
        .bus_rdata_o     (bus_rdata),
        .acc_req_i       (acc_req),
        .acc_we_i        (acc_we),
        .acc_addr_i      (acc_addr),
        .acc_wdata_i     (acc_wdata),
        .acc_be_i        (acc_be),
        .acc_gnt_o       (acc_gnt),
        .acc_rvalid_o    (acc_rvalid),
        .acc_rdata_o     (acc_rdata),
        .set_retentive_i (set_ret),
        .retentive_o     (ret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Holds req until granted; read grants push the expected word.
    task automatic op(input bit acc, input logic we,
                      input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp,
                      output int waited);
        logic g;
        if (acc) begin
            acc_req = 1; acc_we = we; acc_addr = addr;
            acc_wdata = wd; acc_be = be;
        end else begin
            bus_req = 1; bus_we = we; bus_addr = addr;
            bus_wdata = wd; bus_be = be;
        end
        waited = 0;
        forever begin
            @(negedge clk);
            g = acc ? acc_gnt : bus_gnt;
            if (g) break;
            waited++;
            if (waited > 30) begin
                chk(acc ? "acc_gnt_timeout" : "bus_gnt_timeout", 0, 1);
                break;
            end
        end
        if (g && !we) begin
            if (acc) begin
                acc_exp_q.push_back(exp);
                acc_cyc_q.push_back(cyc);
            end else begin
                bus_exp_q.push_back(exp);
                bus_cyc_q.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (acc) acc_req = 0;
        else bus_req = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus_rvalid) begin
                if (bus_exp_q.size() == 0) begin
                    chk("bus_rvalid_unexpected", 1, 0);
                end else begin
                    chk("bus_rdata", bus_rdata, bus_exp_q.pop_front());
                    chk("bus_latency", cyc, bus_cyc_q.pop_front() + 1);
                end
            end
            if (acc_rvalid) begin
                if (acc_exp_q.size() == 0) begin
                    chk("acc_rvalid_unexpected", 1, 0);
                end else begin
                    chk("acc_rdata", acc_rdata, acc_exp_q.pop_front());
                    chk("acc_latency", cyc, acc_cyc_q.pop_front() + 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; set_ret = 0;
        bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; bus_be = 0;
        acc_req = 0; acc_we = 0; acc_addr = 0; acc_wdata = 0; acc_be = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_bus_rvalid", bus_rvalid, 0);
        chk("rst_acc_rvalid", acc_rvalid, 0);
        chk("rst_bus_rdata", bus_rdata, 0);
        chk("rst_acc_rdata", acc_rdata, 0);
        chk("rst_retentive", ret, 0);
        @(posedge clk);
        #1;

        op(0, 1, 12'd5, 32'hDEADBEEF, 4'hF, 0, wb);
        chk("t1_wr_wait", wb, 0);
        op(0, 0, 12'd5, 0, 0, 32'hDEADBEEF, wb);
        chk("t1_rd_wait", wb, 0);

        op(0, 1, 12'd6, 32'hFFFFFFFF, 4'hF, 0, wb);
        op(0, 1, 12'd6, 32'h00000000, 4'b0101, 0, wb);
        op(0, 0, 12'd6, 0, 0, 32'hFF00FF00, wb);

        op(0, 1, 12'd4, 32'h44444444, 4'hF, 0, wb);
        op(1, 1, 12'd8, 32'h88888888, 4'hF, 0, wa);
        chk("t3_acc_wr_wait", wa, 0);
        fork
            op(0, 0, 12'd4, 0, 0, 32'h44444444, wb);
            begin
                for (int k = 0; k < 7; k++) begin
                    op(1, 0, 12'd8, 0, 0, 32'h88888888, wacc[k]);
                end
            end
        join
        chk("t3_bus_losses", wb, 3);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t3_acc_wait%0d", k), wacc[k], exp_wacc[k]);
        end

        op(0, 1, 12'd1, 32'h11111111, 4'hF, 0, wb);
        op(1, 1, 12'd2, 32'h22222222, 4'hF, 0, wa);
        fork
            op(0, 0, 12'd1, 0, 0, 32'h11111111, wb);
            op(1, 0, 12'd2, 0, 0, 32'h22222222, wa);
        join
        chk("t4_bus_wait", wb, 0);
        chk("t4_acc_wait", wa, 0);

        fork
            begin
                set_ret = 1;
                repeat (3) @(posedge clk);
                #1 set_ret = 0;
            end
            begin
                op(0, 0, 12'd5, 0, 0, 32'hDEADBEEF, w1);
                op(0, 0, 12'd5, 0, 0, 32'hDEADBEEF, w2);
            end
            begin
                @(negedge clk);
                chk("t5_ret_entry_cycle", ret, 0);
                @(negedge clk);
                chk("t5_ret_high", ret, 1);
            end
        join
        chk("t5_first_wait", w1, 0);
        chk("t5_blocked_wait", w2, 7);
        chk("t5_ret_low", ret, 0);

        set_ret = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_in_retention", ret, 1);
        @(posedge clk);
        #1 rst = 1; set_ret = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("t6_ret_after_rst", ret, 0);
        @(posedge clk);
        #1;
        op(0, 0, 12'd5, 0, 0, 32'hDEADBEEF, wb);
        chk("t6_gnt_wait", wb, 0);
        op(1, 0, 12'd6, 0, 0, 32'hFF00FF00, wa);
        chk("t6_acc_wait", wa, 0);

        repeat (3) @(negedge clk);
        chk("bus_q_drained", bus_exp_q.size(), 0);
        chk("acc_q_drained", acc_exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
